// File: rtl/mouse_pkg.sv
// mouse_pkg
// Shared definitions for the mouse cursor tracker: data widths, button bit
// positions, default screen size, pipeline register layout and the delta
// scaling helper.
package mouse_pkg;

    localparam int DELTA_W         = 9;   // raw PS/2 movement delta
    localparam int CALC_W          = 13;  // signed internal arithmetic width
    localparam int POS_W           = 10;  // cursor coordinate width
    localparam int BTN_W           = 3;
    localparam int MAX_SPEED_SHIFT = 2;

    localparam int BTN_LEFT   = 0;
    localparam int BTN_RIGHT  = 1;
    localparam int BTN_MIDDLE = 2;

    localparam int DEF_H_RES = 640;
    localparam int DEF_V_RES = 480;

    typedef logic signed [CALC_W-1:0] calc_t;
    typedef logic [POS_W-1:0]         pos_t;
    typedef logic [BTN_W-1:0]         btn_t;
    typedef logic [DELTA_W-1:0]       delta_t;

    // Stage-1 pipeline register contents.
    typedef struct packed {
        logic  valid;
        calc_t dx;
        calc_t dy;
        btn_t  btn;
    } s1_t;

    // Sign-extend a raw 9-bit delta to the arithmetic width, then apply the
    // speed multiplier. With shift <= 2 the result stays within +/-1024.
    function automatic calc_t scale_delta(input delta_t d, input int shift);
        calc_t ext;
        ext = {{(CALC_W-DELTA_W){d[DELTA_W-1]}}, d};
        return ext << shift;
    endfunction

endpackage

// File: rtl/mouse_cursor_tracker_if.sv
// mouse_cursor_tracker_if
// Bundles the packet input, control strobes and cursor outputs of the
// tracker.
//   master : packet source / controller (drives mouse_x..frame_sync)
//   slave  : the tracker (drives cursor_x..disp_y)
// Handshake: packet_ready, recenter and frame_sync are single-cycle strobes
// with no ready/backpressure path; the slave accepts every asserted strobe.
// cursor_valid is a single-cycle pulse marking a cursor/button update.
interface mouse_cursor_tracker_if;
    import mouse_pkg::*;

    delta_t mouse_x;
    delta_t mouse_y;
    btn_t   buttons;
    logic   packet_ready;
    logic   recenter;
    logic   frame_sync;

    pos_t   cursor_x;
    pos_t   cursor_y;
    logic   cursor_valid;
    btn_t   btn_state;
    btn_t   btn_press;
    btn_t   btn_release;
    pos_t   disp_x;
    pos_t   disp_y;

    modport master (
        output mouse_x, mouse_y, buttons, packet_ready, recenter, frame_sync,
        input  cursor_x, cursor_y, cursor_valid, btn_state, btn_press,
               btn_release, disp_x, disp_y
    );

    modport slave (
        input  mouse_x, mouse_y, buttons, packet_ready, recenter, frame_sync,
        output cursor_x, cursor_y, cursor_valid, btn_state, btn_press,
               btn_release, disp_x, disp_y
    );

endinterface

// File: rtl/axis_clamp_accum.sv
// axis_clamp_accum
// Combinational single-axis position update: adds (or subtracts) a signed
// delta to the current position and saturates the result to 0..i_res_max.
// Ports:
//   i_pos     current position (unsigned)
//   i_delta   signed, already-scaled delta
//   i_sub     1 = subtract delta (screen Y grows downward), 0 = add
//   i_res_max largest legal position (RES-1)
//   o_pos     clamped new position
module axis_clamp_accum
    import mouse_pkg::*;
(
    input  pos_t  i_pos,
    input  calc_t i_delta,
    input  logic  i_sub,
    input  pos_t  i_res_max,
    output pos_t  o_pos
);

    calc_t w_base;
    calc_t w_max;
    calc_t w_sum;

    assign w_base = {{(CALC_W-POS_W){1'b0}}, i_pos};
    assign w_max  = {{(CALC_W-POS_W){1'b0}}, i_res_max};
    // Range is -1024..2047, well inside 13-bit signed, so no wrap is possible.
    assign w_sum  = i_sub ? (w_base - i_delta) : (w_base + i_delta);

    always_comb begin
        o_pos = w_sum[POS_W-1:0];
        if (w_sum[CALC_W-1]) begin
            o_pos = '0;
        end else if (w_sum > w_max) begin
            o_pos = i_res_max;
        end
    end

endmodule

// File: rtl/mouse_cursor_tracker.sv
// mouse_cursor_tracker
// Turns decoded PS/2 movement packets into an absolute, screen-clamped
// cursor position, button state with press/release pulses, and a copy of the
// cursor latched at each frame_sync for the video overlay.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high
//   bus    mouse_cursor_tracker_if.slave (packet in, strobes, cursor out)
// Two-stage pipeline: stage 1 registers scaled deltas and buttons, stage 2
// applies them to the live cursor. A packet at cycle N is visible at N+2.
module mouse_cursor_tracker
    import mouse_pkg::*;
#(
    parameter int H_RES       = DEF_H_RES,
    parameter int V_RES       = DEF_V_RES,
    parameter int SPEED_SHIFT = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    mouse_cursor_tracker_if.slave  bus
);

    generate
        if (SPEED_SHIFT < 0 || SPEED_SHIFT > MAX_SPEED_SHIFT) begin : g_bad_speed_shift
            $error("mouse_cursor_tracker: SPEED_SHIFT must be 0..2");
        end
        if (H_RES < 2 || H_RES > (1 << POS_W) || V_RES < 2 || V_RES > (1 << POS_W)) begin : g_bad_res
            $error("mouse_cursor_tracker: H_RES/V_RES must be 2..1024");
        end
    endgenerate

    localparam pos_t CENTRE_X = POS_W'(H_RES / 2);
    localparam pos_t CENTRE_Y = POS_W'(V_RES / 2);
    localparam pos_t MAX_X    = POS_W'(H_RES - 1);
    localparam pos_t MAX_Y    = POS_W'(V_RES - 1);

    s1_t  r_s1;
    pos_t r_cursor_x;
    pos_t r_cursor_y;
    pos_t r_disp_x;
    pos_t r_disp_y;
    logic r_cursor_valid;
    btn_t r_btn_state;
    btn_t r_btn_press;
    btn_t r_btn_release;

    pos_t w_next_x;
    pos_t w_next_y;

    // Stage 2 always reads the live cursor register, so back-to-back packets
    // accumulate without a lost update.
    axis_clamp_accum u_clamp_x (
        .i_pos     (r_cursor_x),
        .i_delta   (r_s1.dx),
        .i_sub     (1'b0),
        .i_res_max (MAX_X),
        .o_pos     (w_next_x)
    );

    // PS/2 Y is up-positive, screen Y is down-positive: subtract.
    axis_clamp_accum u_clamp_y (
        .i_pos     (r_cursor_y),
        .i_delta   (r_s1.dy),
        .i_sub     (1'b1),
        .i_res_max (MAX_Y),
        .o_pos     (w_next_y)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1           <= '0;
            r_cursor_x     <= CENTRE_X;
            r_cursor_y     <= CENTRE_Y;
            r_disp_x       <= CENTRE_X;
            r_disp_y       <= CENTRE_Y;
            r_cursor_valid <= 1'b0;
            r_btn_state    <= '0;
            r_btn_press    <= '0;
            r_btn_release  <= '0;
        end else begin
            // Stage 1: capture the packet.
            r_s1.valid <= bus.packet_ready;
            if (bus.packet_ready) begin
                r_s1.dx  <= scale_delta(bus.mouse_x, SPEED_SHIFT);
                r_s1.dy  <= scale_delta(bus.mouse_y, SPEED_SHIFT);
                r_s1.btn <= bus.buttons;
            end

            // Stage 2: buttons are applied even when recenter overrides the
            // position of the same packet.
            r_cursor_valid <= r_s1.valid | bus.recenter;
            if (r_s1.valid) begin
                r_btn_press   <= r_s1.btn & ~r_btn_state;
                r_btn_release <= ~r_s1.btn & r_btn_state;
                r_btn_state   <= r_s1.btn;
            end else begin
                r_btn_press   <= '0;
                r_btn_release <= '0;
            end

            if (bus.recenter) begin
                r_cursor_x <= CENTRE_X;
                r_cursor_y <= CENTRE_Y;
            end else if (r_s1.valid) begin
                r_cursor_x <= w_next_x;
                r_cursor_y <= w_next_y;
            end

            // Display copy takes the pre-update cursor value.
            if (bus.frame_sync) begin
                r_disp_x <= r_cursor_x;
                r_disp_y <= r_cursor_y;
            end
        end
    end

    assign bus.cursor_x     = r_cursor_x;
    assign bus.cursor_y     = r_cursor_y;
    assign bus.cursor_valid = r_cursor_valid;
    assign bus.btn_state    = r_btn_state;
    assign bus.btn_press    = r_btn_press;
    assign bus.btn_release  = r_btn_release;
    assign bus.disp_x       = r_disp_x;
    assign bus.disp_y       = r_disp_y;

endmodule

// File: tb/tb_mouse_cursor_tracker.sv
module tb_mouse_cursor_tracker;

  logic clk;
  logic reset;

  logic       d_pr;
  logic       d_rc;
  logic       d_fs;
  logic [8:0] d_mx;
  logic [8:0] d_my;
  logic [2:0] d_btn;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs: SPEED_SHIFT 0 and 2 ----------------
  mouse_cursor_tracker_if if0 ();
  mouse_cursor_tracker_if if2 ();

  assign if0.mouse_x = d_mx;
  assign if0.mouse_y = d_my;
  assign if0.buttons = d_btn;
  assign if0.packet_ready = d_pr;
  assign if0.recenter = d_rc;
  assign if0.frame_sync = d_fs;
  assign if2.mouse_x = d_mx;
  assign if2.mouse_y = d_my;
  assign if2.buttons = d_btn;
  assign if2.packet_ready = d_pr;
  assign if2.recenter = d_rc;
  assign if2.frame_sync = d_fs;

  mouse_cursor_tracker #(.H_RES(640), .V_RES(480), .SPEED_SHIFT(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (if0)
  );

  mouse_cursor_tracker #(.H_RES(640), .V_RES(480), .SPEED_SHIFT(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (if2)
  );

  // ---------------- reference model ----------------
  // A packet seen at a clock edge moves the cursor at the following edge;
  // a recenter seen at an edge moves the cursor at that same edge and wins.
  // Index i models the instance with speed multiplier 4**i.
  int         m_x[2], m_y[2], m_dx[2], m_dy[2];
  logic       m_valid[2];
  logic [2:0] m_btn[2], m_press[2], m_rel[2];
  int         m_disp_x[2], m_disp_y[2];
  logic       p_v;
  int         p_dx, p_dy;
  logic [2:0] p_btn;

  function automatic int clampi(input int v, input int res);
    if (v < 0) return 0;
    if (v > res - 1) return res - 1;
    return v;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      p_v <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        m_x[i] <= 320; m_y[i] <= 240;
        m_disp_x[i] <= 320; m_disp_y[i] <= 240;
        m_valid[i] <= 1'b0;
        m_btn[i] <= 3'b000; m_press[i] <= 3'b000; m_rel[i] <= 3'b000;
      end
    end else begin
      p_v   <= d_pr;
      p_dx  <= $signed(d_mx);
      p_dy  <= $signed(d_my);
      p_btn <= d_btn;
      for (int i = 0; i < 2; i++) begin
        m_valid[i] <= p_v | d_rc;
        if (p_v) begin
          m_btn[i]   <= p_btn;
          m_press[i] <= p_btn & ~m_btn[i];
          m_rel[i]   <= ~p_btn & m_btn[i];
        end else begin
          m_press[i] <= 3'b000;
          m_rel[i]   <= 3'b000;
        end
        if (d_rc) begin
          m_x[i] <= 320;
          m_y[i] <= 240;
        end else if (p_v) begin
          m_x[i] <= clampi(m_x[i] + p_dx * (4 ** i), 640);
          m_y[i] <= clampi(m_y[i] - p_dy * (4 ** i), 480);
        end
        if (d_fs) begin
          m_disp_x[i] <= m_x[i];
          m_disp_y[i] <= m_y[i];
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic pr, input logic [8:0] mx, input logic [8:0] my,
                        input logic [2:0] btn, input logic rc, input logic fs);
    d_pr = pr; d_mx = mx; d_my = my; d_btn = btn; d_rc = rc; d_fs = fs;
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    set_in(1'b0, 9'd0, 9'd0, 3'b000, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    if ({if0.cursor_x, if0.cursor_y, if0.disp_x, if0.disp_y} !== {10'd320, 10'd240, 10'd320, 10'd240}) begin
      n_fail++;
      $display("FAIL reset_pos: got x=%0d y=%0d dx=%0d dy=%0d expected 320 240 320 240",
               if0.cursor_x, if0.cursor_y, if0.disp_x, if0.disp_y);
    end
    n_checks++;
    if ({if0.cursor_valid, if0.btn_state, if0.btn_press, if0.btn_release} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_ctl: got valid=%b st=%b pr=%b rl=%b expected all 0",
               if0.cursor_valid, if0.btn_state, if0.btn_press, if0.btn_release);
    end
    n_checks++;
    if ({if2.cursor_x, if2.cursor_y} !== {10'd320, 10'd240}) begin
      n_fail++;
      $display("FAIL reset_pos_s2: got %0d,%0d expected 320,240", if2.cursor_x, if2.cursor_y);
    end
    n_checks++;
  endtask

  task automatic test_basic_move();
    do_reset();
    set_in(1'b1, 9'd10, 9'd5, 3'b000, 1'b0, 1'b0);
    tick();
    idle();
    if ({if0.cursor_valid, if0.cursor_x} !== {1'b0, 10'd320}) begin
      n_fail++;
      $display("FAIL move_latency: got valid=%b x=%0d expected 0 320", if0.cursor_valid, if0.cursor_x);
    end
    n_checks++;
    tick();
    if ({if0.cursor_x, if0.cursor_y, if0.cursor_valid, if0.btn_press, if0.btn_release} !== {10'd330, 10'd235, 1'b1, 6'd0}) begin
      n_fail++;
      $display("FAIL move_result: got x=%0d y=%0d v=%b pr=%b rl=%b expected 330 235 1 000 000",
               if0.cursor_x, if0.cursor_y, if0.cursor_valid, if0.btn_press, if0.btn_release);
    end
    n_checks++;
    tick();
    if ({if0.cursor_valid, if0.cursor_x, if0.cursor_y} !== {1'b0, 10'd330, 10'd235}) begin
      n_fail++;
      $display("FAIL move_hold: got v=%b x=%0d y=%0d expected 0 330 235",
               if0.cursor_valid, if0.cursor_x, if0.cursor_y);
    end
    n_checks++;
  endtask

  task automatic test_clamp();
    do_reset();
    set_in(1'b1, 9'h100, 9'd0, 3'b000, 1'b0, 1'b0);
    tick();
    tick();
    idle();
    if ({if0.cursor_x, if0.cursor_y} !== {10'd64, 10'd240}) begin
      n_fail++;
      $display("FAIL clamp_x1: got %0d,%0d expected 64,240", if0.cursor_x, if0.cursor_y);
    end
    n_checks++;
    tick();
    if ({if0.cursor_x, if0.cursor_y} !== {10'd0, 10'd240}) begin
      n_fail++;
      $display("FAIL clamp_x0: got %0d,%0d expected 0,240", if0.cursor_x, if0.cursor_y);
    end
    n_checks++;
    set_in(1'b1, 9'd0, 9'h101, 3'b000, 1'b0, 1'b0);
    tick();
    tick();
    idle();
    if (if0.cursor_y !== 10'd479) begin
      n_fail++;
      $display("FAIL clamp_y1: got %0d expected 479", if0.cursor_y);
    end
    n_checks++;
    tick();
    if ({if0.cursor_y, if0.cursor_valid} !== {10'd479, 1'b1}) begin
      n_fail++;
      $display("FAIL clamp_y2: got y=%0d v=%b expected 479 1", if0.cursor_y, if0.cursor_valid);
    end
    n_checks++;
  endtask

  task automatic test_buttons();
    logic [2:0] seq [4];
    logic [2:0] exp_pr [4];
    logic [2:0] exp_rl [4];
    seq    = '{3'b000, 3'b001, 3'b011, 3'b010};
    exp_pr = '{3'b000, 3'b001, 3'b010, 3'b000};
    exp_rl = '{3'b000, 3'b000, 3'b000, 3'b001};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_in(1'b1, 9'd0, 9'd0, seq[k], 1'b0, 1'b0);
      tick();
      idle();
      tick();
      if ({if0.btn_state, if0.btn_press, if0.btn_release, if0.cursor_valid} !== {seq[k], exp_pr[k], exp_rl[k], 1'b1}) begin
        n_fail++;
        $display("FAIL buttons[%0d]: got st=%b pr=%b rl=%b v=%b expected %b %b %b 1",
                 k, if0.btn_state, if0.btn_press, if0.btn_release, if0.cursor_valid,
                 seq[k], exp_pr[k], exp_rl[k]);
      end
      n_checks++;
    end
  endtask

  task automatic test_back_to_back();
    int exp2 [3];
    int exp0 [3];
    exp2 = '{332, 344, 356};
    exp0 = '{323, 326, 329};
    do_reset();
    set_in(1'b1, 9'd3, 9'd0, 3'b000, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 3; k++) begin
      if (k == 2) idle();
      tick();
      if ({if2.cursor_x, if2.cursor_valid} !== {10'(exp2[k]), 1'b1}) begin
        n_fail++;
        $display("FAIL b2b_shift2[%0d]: got x=%0d v=%b expected %0d 1", k, if2.cursor_x, if2.cursor_valid, exp2[k]);
      end
      n_checks++;
      if (if0.cursor_x !== 10'(exp0[k])) begin
        n_fail++;
        $display("FAIL b2b_shift0[%0d]: got x=%0d expected %0d", k, if0.cursor_x, exp0[k]);
      end
      n_checks++;
    end
  endtask

  task automatic test_recenter();
    do_reset();
    set_in(1'b1, 9'd80, 9'd140, 3'b000, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    if ({if0.cursor_x, if0.cursor_y} !== {10'd400, 10'd100}) begin
      n_fail++;
      $display("FAIL recenter_setup: got %0d,%0d expected 400,100", if0.cursor_x, if0.cursor_y);
    end
    n_checks++;
    set_in(1'b1, 9'd50, 9'd0, 3'b100, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 9'd0, 9'd0, 3'b000, 1'b1, 1'b0);
    tick();
    idle();
    if ({if0.cursor_x, if0.cursor_y, if0.btn_press, if0.btn_state, if0.cursor_valid} !== {10'd320, 10'd240, 3'b100, 3'b100, 1'b1}) begin
      n_fail++;
      $display("FAIL recenter_collide: got x=%0d y=%0d pr=%b st=%b v=%b expected 320 240 100 100 1",
               if0.cursor_x, if0.cursor_y, if0.btn_press, if0.btn_state, if0.cursor_valid);
    end
    n_checks++;
    set_in(1'b1, 9'd10, 9'd0, 3'b100, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    set_in(1'b0, 9'd0, 9'd0, 3'b000, 1'b1, 1'b0);
    tick();
    idle();
    if ({if0.cursor_x, if0.cursor_valid, if0.btn_press} !== {10'd320, 1'b1, 3'b000}) begin
      n_fail++;
      $display("FAIL recenter_alone: got x=%0d v=%b pr=%b expected 320 1 000",
               if0.cursor_x, if0.cursor_valid, if0.btn_press);
    end
    n_checks++;
  endtask

  task automatic test_frame_sync();
    do_reset();
    set_in(1'b1, 9'd10, 9'd0, 3'b000, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 9'd0, 9'd0, 3'b000, 1'b0, 1'b1);
    tick();
    idle();
    if ({if0.cursor_x, if0.disp_x} !== {10'd330, 10'd320}) begin
      n_fail++;
      $display("FAIL fsync_collide: got cur=%0d disp=%0d expected 330 320", if0.cursor_x, if0.disp_x);
    end
    n_checks++;
    tick();
    set_in(1'b0, 9'd0, 9'd0, 3'b000, 1'b0, 1'b1);
    tick();
    idle();
    if ({if0.disp_x, if0.disp_y} !== {10'd330, 10'd240}) begin
      n_fail++;
      $display("FAIL fsync_next: got disp=%0d,%0d expected 330,240", if0.disp_x, if0.disp_y);
    end
    n_checks++;
  endtask

  task automatic test_random();
    logic [49:0] act0, act2, exp0, exp2;
    do_reset();
    for (int k = 0; k < 600; k++) begin
      reset = (k == 300);
      set_in(1'($urandom_range(0, 1)), 9'($urandom), 9'($urandom), 3'($urandom),
             ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0));
      tick();
      act0 = {if0.cursor_x, if0.cursor_y, if0.cursor_valid, if0.btn_state, if0.btn_press,
              if0.btn_release, if0.disp_x, if0.disp_y};
      act2 = {if2.cursor_x, if2.cursor_y, if2.cursor_valid, if2.btn_state, if2.btn_press,
              if2.btn_release, if2.disp_x, if2.disp_y};
      exp0 = {10'(m_x[0]), 10'(m_y[0]), m_valid[0], m_btn[0], m_press[0], m_rel[0],
              10'(m_disp_x[0]), 10'(m_disp_y[0])};
      exp2 = {10'(m_x[1]), 10'(m_y[1]), m_valid[1], m_btn[1], m_press[1], m_rel[1],
              10'(m_disp_x[1]), 10'(m_disp_y[1])};
      if (act0 !== exp0) begin
        n_fail++;
        $display("FAIL random_s0 cycle %0d: got %h expected %h", k, act0, exp0);
      end
      n_checks++;
      if (act2 !== exp2) begin
        n_fail++;
        $display("FAIL random_s2 cycle %0d: got %h expected %h", k, act2, exp2);
      end
      n_checks++;
    end
    reset = 1'b0;
    idle();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_basic_move();
    test_clamp();
    test_buttons();
    test_back_to_back();
    test_recenter();
    test_frame_sync();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
